// File: rtl/bus_scenario_sequencer.sv
// bus_scenario_sequencer
//   Run-time configurable stimulus sequencer for the bus testbench. A
//   scenario is latched from the cfg_* inputs when start is seen in IDLE.
//   Each participating master then receives a burst of beats. In every beat,
//   m_enable is held for HOLD_CYCLES cycles. The sequencer then waits for all
//   participating masters to drop m_request. Address and write data step by
//   one from beat to beat. A beat that never completes is aborted after
//   TIMEOUT_CYCLES wait cycles.
//
// Ports
//   clk, reset             : rising-edge clock, asynchronous active-high reset
//   start                  : launch a scenario (only looked at in IDLE)
//   cfg_en_mask/rd_mask    : participating masters / read(1) or write(0)
//   cfg_addr/cfg_data      : per-master start address / first write data,
//                            master i at [i*W +: W]
//   cfg_beats              : burst length, 0 behaves as 1
//   m_request              : per-master busy flags from the bus masters
//   m_enable/m_read_en     : per-master transaction enable / read select
//   m_data_in/m_addr_in    : per-master write data / address
//   busy, done, timeout    : status; done and timeout are one-cycle pulses
//   beat_cnt               : beats completed in the current or last scenario
//   state_out              : IDLE=0 DRIVE=1 WAIT=2 DONE=3 ABORT=4
module bus_scenario_sequencer #(
  parameter int NUM_MASTERS    = 2,
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 14,
  parameter int HOLD_CYCLES    = 2,
  parameter int BURST_WIDTH    = 4,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              start,
  input  logic [NUM_MASTERS-1:0]            cfg_en_mask,
  input  logic [NUM_MASTERS-1:0]            cfg_rd_mask,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] cfg_addr,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] cfg_data,
  input  logic [BURST_WIDTH-1:0]            cfg_beats,
  input  logic [NUM_MASTERS-1:0]            m_request,
  output logic [NUM_MASTERS-1:0]            m_enable,
  output logic [NUM_MASTERS-1:0]            m_read_en,
  output logic [NUM_MASTERS*DATA_WIDTH-1:0] m_data_in,
  output logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr_in,
  output logic                              busy,
  output logic                              done,
  output logic                              timeout,
  output logic [BURST_WIDTH-1:0]            beat_cnt,
  output logic [2:0]                        state_out
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DRIVE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DONE  = 3'd3,
    ST_ABORT = 3'd4
  } state_t;

  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int TO_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [HOLD_W-1:0]      HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [TO_W-1:0]        TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [HOLD_W-1:0]      HOLD_ONE  = HOLD_W'(1);
  localparam logic [TO_W-1:0]        TO_ONE    = TO_W'(1);
  localparam logic [BURST_WIDTH-1:0] BEAT_ONE  = BURST_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0]  ADDR_ONE  = ADDR_WIDTH'(1);
  localparam logic [DATA_WIDTH-1:0]  DATA_ONE  = DATA_WIDTH'(1);

  state_t                            state_q, state_d;
  logic [NUM_MASTERS-1:0]            en_mask_q, en_mask_d;
  logic [NUM_MASTERS-1:0]            rd_mask_q, rd_mask_d;
  logic [BURST_WIDTH-1:0]            beats_q, beats_d;
  logic [HOLD_W-1:0]                 hold_q, hold_d;
  logic [TO_W-1:0]                   to_cnt_q, to_cnt_d;
  logic [BURST_WIDTH-1:0]            beat_cnt_q, beat_cnt_d;
  logic [NUM_MASTERS-1:0]            m_enable_q, m_enable_d;
  logic [NUM_MASTERS-1:0]            m_read_en_q, m_read_en_d;
  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_data_q, m_data_d;
  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr_q, m_addr_d;
  logic                              busy_q, busy_d;
  logic                              done_q, done_d;
  logic                              timeout_q, timeout_d;

  // Next-state and next-output logic of the scenario FSM.
  always_comb begin
    state_d     = state_q;
    en_mask_d   = en_mask_q;
    rd_mask_d   = rd_mask_q;
    beats_d     = beats_q;
    hold_d      = hold_q;
    to_cnt_d    = to_cnt_q;
    beat_cnt_d  = beat_cnt_q;
    m_enable_d  = m_enable_q;
    m_read_en_d = m_read_en_q;
    m_data_d    = m_data_q;
    m_addr_d    = m_addr_q;
    done_d      = 1'b0;
    timeout_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        m_enable_d  = {NUM_MASTERS{1'b0}};
        m_read_en_d = {NUM_MASTERS{1'b0}};
        m_data_d    = {(NUM_MASTERS*DATA_WIDTH){1'b0}};
        m_addr_d    = {(NUM_MASTERS*ADDR_WIDTH){1'b0}};
        if (start) begin
          en_mask_d  = cfg_en_mask;
          rd_mask_d  = cfg_rd_mask;
          beats_d    = (cfg_beats == {BURST_WIDTH{1'b0}}) ? BEAT_ONE : cfg_beats;
          beat_cnt_d = {BURST_WIDTH{1'b0}};
          hold_d     = {HOLD_W{1'b0}};
          to_cnt_d   = {TO_W{1'b0}};
          if (cfg_en_mask != {NUM_MASTERS{1'b0}}) begin
            state_d     = ST_DRIVE;
            m_enable_d  = cfg_en_mask;
            m_read_en_d = cfg_en_mask & cfg_rd_mask;
            // Disabled masters keep all-zero outputs; read masters get no data.
            for (int i = 0; i < NUM_MASTERS; i++) begin
              if (cfg_en_mask[i]) begin
                m_addr_d[i*ADDR_WIDTH +: ADDR_WIDTH] = cfg_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
              end else begin
                m_addr_d[i*ADDR_WIDTH +: ADDR_WIDTH] = {ADDR_WIDTH{1'b0}};
              end
              if (cfg_en_mask[i] && !cfg_rd_mask[i]) begin
                m_data_d[i*DATA_WIDTH +: DATA_WIDTH] = cfg_data[i*DATA_WIDTH +: DATA_WIDTH];
              end else begin
                m_data_d[i*DATA_WIDTH +: DATA_WIDTH] = {DATA_WIDTH{1'b0}};
              end
            end
          end else begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_DRIVE: begin
        if (hold_q == HOLD_LAST) begin
          state_d    = ST_WAIT;
          m_enable_d = {NUM_MASTERS{1'b0}};
          to_cnt_d   = {TO_W{1'b0}};
        end else begin
          hold_d = hold_q + HOLD_ONE;
        end
      end

      ST_WAIT: begin
        // Completion wins over timeout when both happen on the same edge.
        if ((m_request & en_mask_q) == {NUM_MASTERS{1'b0}}) begin
          beat_cnt_d = beat_cnt_q + BEAT_ONE;
          if (beat_cnt_d < beats_q) begin
            state_d    = ST_DRIVE;
            hold_d     = {HOLD_W{1'b0}};
            m_enable_d = en_mask_q;
            for (int i = 0; i < NUM_MASTERS; i++) begin
              if (en_mask_q[i]) begin
                m_addr_d[i*ADDR_WIDTH +: ADDR_WIDTH] = m_addr_q[i*ADDR_WIDTH +: ADDR_WIDTH] + ADDR_ONE;
              end else begin
                m_addr_d[i*ADDR_WIDTH +: ADDR_WIDTH] = {ADDR_WIDTH{1'b0}};
              end
              if (en_mask_q[i] && !rd_mask_q[i]) begin
                m_data_d[i*DATA_WIDTH +: DATA_WIDTH] = m_data_q[i*DATA_WIDTH +: DATA_WIDTH] + DATA_ONE;
              end else begin
                m_data_d[i*DATA_WIDTH +: DATA_WIDTH] = {DATA_WIDTH{1'b0}};
              end
            end
          end else begin
            state_d     = ST_DONE;
            done_d      = 1'b1;
            m_read_en_d = {NUM_MASTERS{1'b0}};
            m_data_d    = {(NUM_MASTERS*DATA_WIDTH){1'b0}};
            m_addr_d    = {(NUM_MASTERS*ADDR_WIDTH){1'b0}};
          end
        end else if (to_cnt_q == TO_LAST) begin
          state_d     = ST_ABORT;
          timeout_d   = 1'b1;
          m_read_en_d = {NUM_MASTERS{1'b0}};
          m_data_d    = {(NUM_MASTERS*DATA_WIDTH){1'b0}};
          m_addr_d    = {(NUM_MASTERS*ADDR_WIDTH){1'b0}};
        end else begin
          to_cnt_d = to_cnt_q + TO_ONE;
        end
      end

      ST_DONE, ST_ABORT: begin
        state_d     = ST_IDLE;
        m_enable_d  = {NUM_MASTERS{1'b0}};
        m_read_en_d = {NUM_MASTERS{1'b0}};
        m_data_d    = {(NUM_MASTERS*DATA_WIDTH){1'b0}};
        m_addr_d    = {(NUM_MASTERS*ADDR_WIDTH){1'b0}};
      end

      default: begin
        state_d     = ST_IDLE;
        m_enable_d  = {NUM_MASTERS{1'b0}};
        m_read_en_d = {NUM_MASTERS{1'b0}};
        m_data_d    = {(NUM_MASTERS*DATA_WIDTH){1'b0}};
        m_addr_d    = {(NUM_MASTERS*ADDR_WIDTH){1'b0}};
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State, latched configuration, counters and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      en_mask_q   <= {NUM_MASTERS{1'b0}};
      rd_mask_q   <= {NUM_MASTERS{1'b0}};
      beats_q     <= {BURST_WIDTH{1'b0}};
      hold_q      <= {HOLD_W{1'b0}};
      to_cnt_q    <= {TO_W{1'b0}};
      beat_cnt_q  <= {BURST_WIDTH{1'b0}};
      m_enable_q  <= {NUM_MASTERS{1'b0}};
      m_read_en_q <= {NUM_MASTERS{1'b0}};
      m_data_q    <= {(NUM_MASTERS*DATA_WIDTH){1'b0}};
      m_addr_q    <= {(NUM_MASTERS*ADDR_WIDTH){1'b0}};
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      en_mask_q   <= en_mask_d;
      rd_mask_q   <= rd_mask_d;
      beats_q     <= beats_d;
      hold_q      <= hold_d;
      to_cnt_q    <= to_cnt_d;
      beat_cnt_q  <= beat_cnt_d;
      m_enable_q  <= m_enable_d;
      m_read_en_q <= m_read_en_d;
      m_data_q    <= m_data_d;
      m_addr_q    <= m_addr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      timeout_q   <= timeout_d;
    end
  end

  assign m_enable  = m_enable_q;
  assign m_read_en = m_read_en_q;
  assign m_data_in = m_data_q;
  assign m_addr_in = m_addr_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign timeout   = timeout_q;
  assign beat_cnt  = beat_cnt_q;
  assign state_out = state_q;

endmodule

// File: tb/tb_bus_scenario_sequencer.sv
// Self-checking bench for bus_scenario_sequencer. It builds a timeline for
// each scenario from the rules: the start and end cycle of every beat, the
// request drop points and the final done or abort cycle. Each cycle it
// compares the DUT outputs with the values derived from that timeline.
module tb_bus_scenario_sequencer;
  localparam int NM   = 2;
  localparam int DW   = 8;
  localparam int AW   = 14;
  localparam int HOLD = 2;
  localparam int BW   = 4;
  localparam int TO   = 1023;
  localparam int NAW  = NM * AW;
  localparam int NDW  = NM * DW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           reset, start;
  logic [NM-1:0]  cfg_en_mask, cfg_rd_mask, m_request;
  logic [NAW-1:0] cfg_addr;
  logic [NDW-1:0] cfg_data;
  logic [BW-1:0]  cfg_beats;
  logic [NM-1:0]  m_enable, m_read_en;
  logic [NDW-1:0] m_data_in;
  logic [NAW-1:0] m_addr_in;
  logic           busy, done, timeout;
  logic [BW-1:0]  beat_cnt;
  logic [2:0]     state_out;

  bus_scenario_sequencer dut (
    .clk(clk), .reset(reset), .start(start),
    .cfg_en_mask(cfg_en_mask), .cfg_rd_mask(cfg_rd_mask),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_beats(cfg_beats),
    .m_request(m_request), .m_enable(m_enable), .m_read_en(m_read_en),
    .m_data_in(m_data_in), .m_addr_in(m_addr_in), .busy(busy), .done(done),
    .timeout(timeout), .beat_cnt(beat_cnt), .state_out(state_out)
  );

  // Wider build: 4 masters, 16-bit data.
  logic          s4;
  logic [3:0]    e4, r4, q4, en4o, rd4o;
  logic [55:0]   a4, ao4;
  logic [63:0]   d4, do4;
  logic [BW-1:0] b4, bc4;
  logic          busy4, done4, to4;
  logic [2:0]    st4;

  bus_scenario_sequencer #(.NUM_MASTERS(4), .DATA_WIDTH(16)) dut4 (
    .clk(clk), .reset(reset), .start(s4),
    .cfg_en_mask(e4), .cfg_rd_mask(r4), .cfg_addr(a4), .cfg_data(d4),
    .cfg_beats(b4), .m_request(q4), .m_enable(en4o), .m_read_en(rd4o),
    .m_data_in(do4), .m_addr_in(ao4), .busy(busy4), .done(done4),
    .timeout(to4), .beat_cnt(bc4), .state_out(st4)
  );

  int errors = 0;
  int checks = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Scenario timeline
  logic [NM-1:0] s_en, s_rd;
  int  s_addr [NM];
  int  s_data [NM];
  int  nbeats, final_n, fcount;
  bit  is_abort;
  int  bstart [16];
  int  bend   [16];
  int  rm     [16][NM];

  task automatic plan(input logic [NM-1:0] en, input logic [NM-1:0] rd,
                      input logic [NAW-1:0] a, input logic [NDW-1:0] d,
                      input logic [BW-1:0] b, input int abort_at);
    int t, nb, rmax;
    s_en = en; s_rd = rd;
    for (int i = 0; i < NM; i++) begin
      s_addr[i] = int'(a[i*AW +: AW]);
      s_data[i] = int'(d[i*DW +: DW]);
    end
    is_abort = 1'b0; nbeats = 0; final_n = 0; t = 0;
    nb = (b == '0) ? 1 : int'(b);
    if (en != '0) begin
      for (int k = 0; k < nb; k++) begin
        bstart[k] = t;
        rmax = 0;
        for (int i = 0; i < NM; i++) begin
          rm[k][i] = int'($urandom_range(0, 3));
          if (en[i] && rm[k][i] > rmax) rmax = rm[k][i];
        end
        nbeats = k + 1;
        if (k == abort_at) begin
          bend[k] = t + HOLD + TO;
          is_abort = 1'b1;
          break;
        end
        bend[k] = t + HOLD + 1 + rmax;
        t = bend[k];
      end
      final_n = bend[nbeats-1];
    end
    fcount = is_abort ? nbeats - 1 : nbeats;
  endtask

  // Expected packed outputs n cycles after the start edge.
  function automatic logic [63:0] model_out(input int n);
    logic [NM-1:0]  e_o, r_o;
    logic [NDW-1:0] d_o;
    logic [NAW-1:0] a_o;
    logic           b_o, dn_o, t_o;
    logic [BW-1:0]  c_o;
    logic [2:0]     st;
    e_o = '0; r_o = '0; d_o = '0; a_o = '0;
    b_o = 1'b0; dn_o = 1'b0; t_o = 1'b0; c_o = '0; st = 3'd0;
    if (n == final_n) begin
      b_o = 1'b1; st = is_abort ? 3'd4 : 3'd3;
      dn_o = !is_abort; t_o = is_abort; c_o = BW'(fcount);
    end else if (n > final_n) begin
      c_o = BW'(fcount);
    end else begin
      for (int k = 0; k < nbeats; k++) begin
        if (n >= bstart[k] && n < bend[k]) begin
          b_o = 1'b1;
          c_o = BW'(k);
          st  = (n - bstart[k] < HOLD) ? 3'd1 : 3'd2;
          e_o = (st == 3'd1) ? s_en : '0;
          r_o = s_en & s_rd;
          for (int i = 0; i < NM; i++) begin
            if (s_en[i]) a_o[i*AW +: AW] = AW'(s_addr[i] + k);
            if (s_en[i] && !s_rd[i]) d_o[i*DW +: DW] = DW'(s_data[i] + k);
          end
        end
      end
    end
    return 64'({e_o, r_o, d_o, a_o, b_o, dn_o, t_o, c_o, st});
  endfunction

  function automatic logic [63:0] obs();
    return 64'({m_enable, m_read_en, m_data_in, m_addr_in, busy, done, timeout, beat_cnt, state_out});
  endfunction

  // Request value to present at the edge m cycles after start.
  function automatic logic [NM-1:0] req_for(input int m);
    logic [NM-1:0] r;
    r = NM'($urandom);
    for (int k = 0; k < nbeats; k++) begin
      if (m > bstart[k] && m <= bend[k]) begin
        for (int i = 0; i < NM; i++) begin
          if (s_en[i]) begin
            if (is_abort && k == nbeats - 1) r[i] = 1'b1;
            else r[i] = ((m - bstart[k]) < (HOLD + 1 + rm[k][i])) ? 1'b1 : 1'b0;
          end
        end
      end
    end
    return r;
  endfunction

  task automatic run_scn(input logic [NM-1:0] en, input logic [NM-1:0] rd,
                         input logic [NAW-1:0] a, input logic [NDW-1:0] d,
                         input logic [BW-1:0] b, input int abort_at);
    plan(en, rd, a, d, b, abort_at);
    cfg_en_mask = en; cfg_rd_mask = rd; cfg_addr = a; cfg_data = d; cfg_beats = b;
    start = 1'b1;
    m_request = req_for(0);
    for (int n = 0; n <= final_n + 1; n++) begin
      @(posedge clk); #1;
      // Starts while busy must be ignored; config changes must not leak in.
      start = (n <= final_n && $urandom_range(0, 3) == 0) ? 1'b1 : 1'b0;
      cfg_en_mask = NM'($urandom); cfg_rd_mask = NM'($urandom);
      cfg_addr = NAW'($urandom); cfg_data = NDW'($urandom); cfg_beats = BW'($urandom);
      check_val($sformatf("cycle%0d", n), obs(), model_out(n));
      m_request = req_for(n + 1);
    end
    start = 1'b0;
  endtask

  task automatic idle(input int g);
    start = 1'b0;
    repeat (g) begin
      @(posedge clk); #1;
      m_request = NM'($urandom);
      check_val("idle", obs(), model_out(final_n + 2));
    end
  endtask

  initial begin
    int nab, nbc, ab;
    logic [BW-1:0] rb;
    reset = 1'b1; start = 1'b0; m_request = '0;
    cfg_en_mask = '0; cfg_rd_mask = '0; cfg_addr = '0; cfg_data = '0; cfg_beats = '0;
    s4 = 1'b0; e4 = '0; r4 = '0; q4 = '0; a4 = '0; d4 = '0; b4 = '0;
    final_n = 0; fcount = 0; nbeats = 0; is_abort = 1'b0; nab = 0;
    #12;
    check_val("reset", obs(), 64'd0);
    reset = 1'b0;
    idle(2);

    run_scn(2'b01, 2'b00, {14'd777, 14'd1001}, {8'd55, 8'd101}, 4'd1, -1);
    idle(1);
    run_scn(2'b11, 2'b11, {14'd5097, 14'd5098}, {8'd9, 8'd7}, 4'd3, -1);
    run_scn(2'b01, 2'b00, {14'd5, 14'd16383}, {8'd3, 8'd255}, 4'd2, -1);
    run_scn(2'b10, 2'b00, {14'd100, 14'd200}, {8'd1, 8'd2}, 4'd2, 0);
    run_scn(2'b11, 2'b01, {14'd16382, 14'd40}, {8'd254, 8'd80}, 4'd4, 2);
    run_scn(2'b00, 2'b11, {14'd1, 14'd2}, {8'd3, 8'd4}, 4'd5, -1);
    run_scn(2'b11, 2'b10, {14'd300, 14'd16383}, {8'd17, 8'd255}, 4'd0, -1);

    for (int s = 0; s < 30; s++) begin
      rb  = BW'($urandom);
      nbc = (rb == '0) ? 1 : int'(rb);
      ab  = -1;
      if (nab < 2 && $urandom_range(0, 9) == 0) begin
        ab = int'($urandom_range(0, nbc - 1));
        nab++;
      end
      run_scn(NM'($urandom), NM'($urandom), NAW'($urandom), NDW'($urandom), rb, ab);
      idle(int'($urandom_range(0, 2)));
    end

    // Reset while waiting for a request that never drops.
    plan(2'b11, 2'b00, {14'd10, 14'd20}, {8'd30, 8'd40}, 4'd3, 0);
    cfg_en_mask = 2'b11; cfg_rd_mask = 2'b00; cfg_addr = {14'd10, 14'd20};
    cfg_data = {8'd30, 8'd40}; cfg_beats = 4'd3;
    start = 1'b1;
    m_request = req_for(0);
    for (int n = 0; n <= HOLD + 3; n++) begin
      @(posedge clk); #1;
      start = 1'b0;
      check_val("pre_reset", obs(), model_out(n));
      m_request = req_for(n + 1);
    end
    #2 reset = 1'b1;
    #1 check_val("async_reset", obs(), 64'd0);
    @(posedge clk); #1;
    check_val("reset_hold", obs(), 64'd0);
    reset = 1'b0;
    final_n = 0; fcount = 0; nbeats = 0; is_abort = 1'b0;
    idle(3);

    // Four-master packing: masters 1 and 3 enabled, master 3 reads.
    e4 = 4'b1010; r4 = 4'b1000; b4 = 4'd1; q4 = 4'b0000;
    a4 = {14'd3003, 14'd2002, 14'd1001, 14'd9};
    d4 = {16'hDDDD, 16'hCCCC, 16'hBBBB, 16'hAAAA};
    s4 = 1'b1;
    @(posedge clk); #1;
    s4 = 1'b0;
    check_val("m4_en",   64'(en4o), 64'(4'b1010));
    check_val("m4_rd",   64'(rd4o), 64'(4'b1000));
    check_val("m4_data", do4, {16'h0000, 16'h0000, 16'hBBBB, 16'h0000});
    check_val("m4_addr", 64'(ao4), 64'({14'd3003, 14'd0, 14'd1001, 14'd0}));
    @(posedge clk); #1;
    check_val("m4_hold", 64'({en4o, st4}), 64'({4'b1010, 3'd1}));
    @(posedge clk); #1;
    check_val("m4_wait", 64'({en4o, rd4o, st4}), 64'({4'b0000, 4'b1000, 3'd2}));
    @(posedge clk); #1;
    check_val("m4_done", 64'({done4, to4, busy4, bc4, st4, do4 == 64'd0}),
              64'({1'b1, 1'b0, 1'b1, 4'd1, 3'd3, 1'b1}));
    @(posedge clk); #1;
    check_val("m4_idle", 64'({done4, busy4, bc4, st4, en4o}),
              64'({1'b0, 1'b0, 4'd1, 3'd0, 4'b0000}));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
